// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
// Runs the per-frame game-object update clients (paddles, ball, score) strictly
// inside vertical blanking. A rising edge of vblank starts a sequence that grants
// each client in index order with a one-cycle start pulse and waits for its done
// (or a timeout). Leaving blanking before the sequence finishes aborts it.
//
// Ports:
//   i_Clk        pixel clock
//   i_Rst_L      asynchronous active-low reset
//   i_col_num    current column from the sync generator (not used for scheduling)
//   i_row_num    current row from the sync generator
//   i_enable     scheduling allowed; sampled only on the vblank rising edge
//   i_done       per-client completion, only the granted client's bit is looked at
//   o_start      one-hot, one-cycle start pulse to the granted client
//   o_busy       a sequence is in progress
//   o_frame_cnt  number of accepted vblank triggers, wrapping
//   o_timeout    per-client timeout flags of the current/last sequence
//   o_overrun    sticky: a sequence was aborted or a trigger arrived mid-sequence
module frame_update_scheduler #(
    parameter int unsigned ACTIVE_ROWS    = 480,
    parameter int unsigned TOTAL_ROWS     = 525,
    parameter int unsigned NUM_CLIENTS    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned FRAME_CNT_W    = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [9:0]             i_col_num,
    input  logic [9:0]             i_row_num,
    input  logic                   i_enable,
    input  logic [NUM_CLIENTS-1:0] i_done,
    output logic [NUM_CLIENTS-1:0] o_start,
    output logic                   o_busy,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic [NUM_CLIENTS-1:0] o_timeout,
    output logic                   o_overrun
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [9:0]       VBLANK_ROW = 10'(ACTIVE_ROWS);
    localparam logic [9:0]       LAST_ROW   = 10'(TOTAL_ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic             vb_q;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] to_cnt;

    logic vblank;
    logic trigger;
    logic end_edge;
    logic client_done;
    logic client_expired;

    // Column position and frame height do not influence scheduling.
    logic unused_inputs;
    assign unused_inputs = ^{i_col_num, LAST_ROW};

    // Blanking edge detection from the sampled row counter.
    assign vblank   = (i_row_num >= VBLANK_ROW);
    assign trigger  = vblank & ~vb_q;
    assign end_edge = ~vblank & vb_q;

    // Completion terms for the granted client; done has priority over expiry.
    assign client_done    = i_done[idx];
    assign client_expired = (to_cnt == CNT_LIMIT);

    // Scheduler state machine with registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            vb_q        <= 1'b0;
            idx         <= '0;
            to_cnt      <= '0;
            o_start     <= '0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
            o_timeout   <= '0;
            o_overrun   <= 1'b0;
        end else begin
            vb_q    <= vblank;
            o_start <= '0;

            // A second trigger mid-sequence means the counters are malformed.
            if (trigger && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger && i_enable) begin
                        state       <= ISSUE;
                        idx         <= '0;
                        o_frame_cnt <= o_frame_cnt + 1'b1;
                        o_timeout   <= '0;
                        o_busy      <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (end_edge) begin
                        state     <= IDLE;
                        idx       <= '0;
                        o_busy    <= 1'b0;
                        o_overrun <= 1'b1;
                    end else begin
                        o_start <= NUM_CLIENTS'(1) << idx;
                        to_cnt  <= '0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (end_edge) begin
                        state     <= IDLE;
                        idx       <= '0;
                        o_busy    <= 1'b0;
                        o_overrun <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (client_done || client_expired) begin
                            if (!client_done) begin
                                o_timeout[idx] <= 1'b1;
                            end
                            if (idx < LAST_IDX) begin
                                idx   <= idx + 1'b1;
                                state <= ISSUE;
                            end else begin
                                idx    <= '0;
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
